comms_router: RTL

// Byte-stream command engine between the UART rx/tx byte layer and NUM_CHANNELS same-width BRAM ports.

---
 rtl/comms_router.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/comms_router.sv
// Byte-stream command engine: decodes 4-byte headers from the UART byte layer and
// moves words between the host and NUM_CHANNELS BRAM ports, acknowledging writes.
module comms_router #(
  parameter int NUM_CHANNELS   = 4,
  parameter int WORD_BYTES     = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 250000
) (
  input  logic                               clk_in,
  input  logic                               rst_n_in,
  input  logic [7:0]                         rx_byte_in,
  input  logic                               rx_valid_in,
  output logic [7:0]                         tx_byte_out,
  output logic                               tx_valid_out,
  input  logic                               tx_ready_in,
  output logic                               busy_out,
  output logic [ADDR_WIDTH-1:0]              mem_addr_out,
  output logic [8*WORD_BYTES-1:0]            mem_wdata_out,
  output logic [NUM_CHANNELS-1:0]            mem_we_out,
  output logic [NUM_CHANNELS-1:0]            mem_re_out,
  input  logic [NUM_CHANNELS*8*WORD_BYTES-1:0] mem_rdata_in,
  output logic [7:0]                         timeout_count_out
);

  localparam int WW  = 8 * WORD_BYTES;
  localparam int BCW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LTW = 3;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NACK_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    S_HDR, S_WR_DATA, S_WR_DISCARD, S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_RESP
  } state_t;

  state_t                   state_q;
  logic [1:0]               hdr_cnt_q;
  logic                     rd_q;
  logic [3:0]               chan_q;
  logic [7:0]               addr_lo_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [8:0]               words_q;
  logic [BCW-1:0]           byte_q;
  logic [LTW-1:0]           lat_q;
  logic [TMW-1:0]           timer_q;
  logic [WW-1:0]            wdata_q;
  logic [WW-1:0]            rword_q;
  logic [NUM_CHANNELS-1:0]  we_q;
  logic [NUM_CHANNELS-1:0]  re_q;
  logic [7:0]               tx_byte_q;
  logic                     tx_valid_q;
  logic [7:0]               tout_q;

  logic                     chan_ok_s;
  logic                     timed_s;
  logic                     expire_s;
  logic [WW-1:0]            rslice_s;

  function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [3:0] c);
    logic [NUM_CHANNELS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) v[i] = (c == 4'(i));
    return v;
  endfunction

  assign chan_ok_s = int'(chan_q) < NUM_CHANNELS;
  assign timed_s   = ((state_q == S_HDR) && (hdr_cnt_q != 2'd0)) ||
                     (state_q == S_WR_DATA) || (state_q == S_WR_DISCARD);
  assign expire_s  = timed_s && !rx_valid_in && (timer_q == TMW'(TIMEOUT_CYCLES - 1));

  // Select the addressed channel's read word.
  always_comb begin
    rslice_s = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      rslice_s = (chan_q == 4'(c)) ? mem_rdata_in[c*WW +: WW] : rslice_s;
    end
  end

  // Command FSM with all outputs registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_HDR;
      hdr_cnt_q  <= 2'd0;
      rd_q       <= 1'b0;
      chan_q     <= 4'd0;
      addr_lo_q  <= 8'd0;
      addr_q     <= '0;
      words_q    <= 9'd0;
      byte_q     <= '0;
      lat_q      <= '0;
      timer_q    <= '0;
      wdata_q    <= '0;
      rword_q    <= '0;
      we_q       <= '0;
      re_q       <= '0;
      tx_byte_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      tout_q     <= 8'd0;
    end else begin
      we_q <= '0;
      re_q <= '0;
      // A write strobe uses the current address; step it once the strobe is done.
      if (we_q != '0) addr_q <= addr_q + ADDR_WIDTH'(1);
      timer_q <= (timed_s && !rx_valid_in) ? timer_q + TMW'(1) : '0;
      if (expire_s) begin
        state_q   <= S_HDR;
        hdr_cnt_q <= 2'd0;
        timer_q   <= '0;
        if (tout_q != 8'hFF) tout_q <= tout_q + 8'd1;
      end else begin
        case (state_q)
          S_HDR: begin
            if (rx_valid_in) begin
              hdr_cnt_q <= hdr_cnt_q + 2'd1;
              case (hdr_cnt_q)
                2'd0: begin
                  rd_q   <= rx_byte_in[7];
                  chan_q <= rx_byte_in[3:0];
                end
                2'd1: addr_lo_q <= rx_byte_in;
                2'd2: addr_q <= ADDR_WIDTH'({rx_byte_in, addr_lo_q});
                default: begin
                  words_q <= {1'b0, rx_byte_in} + 9'd1;
                  byte_q  <= '0;
                  if (!rd_q && chan_ok_s) begin
                    state_q <= S_WR_DATA;
                  end else if (!rd_q) begin
                    state_q <= S_WR_DISCARD;
                  end else if (chan_ok_s) begin
                    state_q <= S_RD_REQ;
                  end else begin
                    state_q    <= S_RESP;
                    tx_byte_q  <= NACK_BYTE;
                    tx_valid_q <= 1'b1;
                  end
                end
              endcase
            end
          end
          S_WR_DATA, S_WR_DISCARD: begin
            if (rx_valid_in) begin
              // Shift in from the top so byte 0 lands in the least significant lane.
              if (state_q == S_WR_DATA) wdata_q <= {rx_byte_in, wdata_q[WW-1:8]};
              if (byte_q == BCW'(WORD_BYTES - 1)) begin
                byte_q  <= '0;
                words_q <= words_q - 9'd1;
                if (state_q == S_WR_DATA) we_q <= onehot(chan_q);
                if (words_q == 9'd1) begin
                  state_q    <= S_RESP;
                  tx_byte_q  <= (state_q == S_WR_DATA) ? ACK_BYTE : NACK_BYTE;
                  tx_valid_q <= 1'b1;
                end
              end else begin
                byte_q <= byte_q + BCW'(1);
              end
            end
          end
          S_RD_REQ: begin
            re_q    <= onehot(chan_q);
            lat_q   <= '0;
            state_q <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            if (lat_q == LTW'(READ_LATENCY)) begin
              tx_byte_q  <= rslice_s[7:0];
              rword_q    <= {8'h00, rslice_s[WW-1:8]};
              tx_valid_q <= 1'b1;
              byte_q     <= '0;
              state_q    <= S_RD_SEND;
            end else begin
              lat_q <= lat_q + LTW'(1);
            end
          end
          S_RD_SEND: begin
            if (tx_ready_in) begin
              if (byte_q == BCW'(WORD_BYTES - 1)) begin
                tx_valid_q <= 1'b0;
                addr_q     <= addr_q + ADDR_WIDTH'(1);
                words_q    <= words_q - 9'd1;
                state_q    <= (words_q == 9'd1) ? S_HDR : S_RD_REQ;
              end else begin
                tx_byte_q <= rword_q[7:0];
                rword_q   <= {8'h00, rword_q[WW-1:8]};
                byte_q    <= byte_q + BCW'(1);
              end
            end
          end
          S_RESP: begin
            if (tx_ready_in) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_HDR;
            end
          end
          default: begin
            state_q    <= S_HDR;
            hdr_cnt_q  <= 2'd0;
            tx_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx_byte_out       = tx_byte_q;
  assign tx_valid_out      = tx_valid_q;
  assign busy_out          = (state_q != S_HDR) || (hdr_cnt_q != 2'd0);
  assign mem_addr_out      = addr_q;
  assign mem_wdata_out     = wdata_q;
  assign mem_we_out        = we_q;
  assign mem_re_out        = re_q;
  assign timeout_count_out = tout_q;

endmodule
